// File: rtl/gte_dot_accum.sv
// gte_dot_accum: multi-lane signed dot-product accumulator with
// valid/ready beats in, registered saturated result out.
// Ports: i_clk, i_rst (sync, active-high); beat in: i_valid/o_ready,
//   i_first, i_last, i_a, i_b, i_neg, i_bias, i_sf, i_lm;
//   result out: o_valid/i_ready, o_mac, o_ir, o_irSat, o_ovfPos,
//   o_ovfNeg, o_z16, o_zSat.
// Option: define GTE_DOT_ACCUM_ZCLAMP_EN to drive o_z16/o_zSat from
//   clamp(acc>>>12, 0, 0xFFFF); otherwise both are tied to zero.
module gte_dot_accum #(
  parameter int LANES = 3,
  parameter int OPW   = 16,
  parameter int ACCW  = 44
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_first,
  input  logic                  i_last,
  input  logic [LANES*OPW-1:0]  i_a,
  input  logic [LANES*OPW-1:0]  i_b,
  input  logic [LANES-1:0]      i_neg,
  input  logic [ACCW-1:0]       i_bias,
  input  logic                  i_sf,
  input  logic                  i_lm,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [31:0]           o_mac,
  output logic [15:0]           o_ir,
  output logic                  o_irSat,
  output logic                  o_ovfPos,
  output logic                  o_ovfNeg,
  output logic [15:0]           o_z16,
  output logic                  o_zSat
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Two guard bits above the accumulator expose overflow.
  localparam int SW = ACCW + 2;

  localparam logic signed [ACCW-1:0] IR_MAX = 32767;
  localparam logic signed [ACCW-1:0] IR_MIN = -32768;

  function automatic logic signed [SW-1:0] lane_prod(
    input logic signed [OPW-1:0] a,
    input logic signed [OPW-1:0] b,
    input logic                  n
  );
    logic signed [2*OPW-1:0] p;
    logic signed [SW-1:0]    pe;
    p  = a * b;
    pe = SW'(p);
    return n ? -pe : pe;
  endfunction

  logic [1:0]             state;
  logic signed [ACCW-1:0] acc;
  logic                   ovf_pos;
  logic                   ovf_neg;

  logic                   take;
  logic                   load;
  logic signed [SW-1:0]   dot;
  logic signed [SW-1:0]   base;
  logic signed [SW-1:0]   sum;
  logic                   ovp;
  logic                   ovn;
  logic signed [ACCW-1:0] acc_nxt;
  logic signed [ACCW-1:0] mac;
  logic signed [ACCW-1:0] ir_lo;
  logic [15:0]            ir_nxt;
  logic                   ir_sat_nxt;
  logic [15:0]            z_nxt;
  logic                   z_sat_nxt;

  assign o_ready  = (state != DONE) | i_ready;
  assign o_valid  = (state == DONE);
  assign o_ovfPos = ovf_pos;
  assign o_ovfNeg = ovf_neg;

  assign take = i_valid & o_ready;
  // Any beat outside ACCUM, or a first beat, opens a fresh operation.
  assign load = i_first | (state != ACCUM);

  always_comb begin
    dot = '0;
    for (int k = 0; k < LANES; k++) begin
      dot = dot + lane_prod(i_a[k*OPW +: OPW],
                            i_b[k*OPW +: OPW],
                            i_neg[k]);
    end
  end

  always_comb begin
    base = '0;
    if (!load)
      base = SW'(acc);
    else if (i_first)
      base = SW'($signed(i_bias));
  end

  assign sum     = base + dot;
  assign ovp     = ~sum[SW-1] & (|sum[SW-2:ACCW-1]);
  assign ovn     = sum[SW-1] & ~(&sum[SW-2:ACCW-1]);
  assign acc_nxt = sum[ACCW-1:0];
  assign mac     = i_sf ? (acc_nxt >>> 12) : acc_nxt;
  assign ir_lo   = i_lm ? '0 : IR_MIN;

  always_comb begin
    ir_nxt     = mac[15:0];
    ir_sat_nxt = 1'b0;
    if (mac > IR_MAX) begin
      ir_nxt     = 16'h7FFF;
      ir_sat_nxt = 1'b1;
    end else if (mac < ir_lo) begin
      ir_nxt     = ir_lo[15:0];
      ir_sat_nxt = 1'b1;
    end
  end

`ifdef GTE_DOT_ACCUM_ZCLAMP_EN
  localparam logic signed [ACCW-1:0] Z_MAX = 65535;
  logic signed [ACCW-1:0] zs;
  assign zs = acc_nxt >>> 12;
  always_comb begin
    z_nxt     = zs[15:0];
    z_sat_nxt = 1'b0;
    if (zs < 0) begin
      z_nxt     = 16'h0000;
      z_sat_nxt = 1'b1;
    end else if (zs > Z_MAX) begin
      z_nxt     = 16'hFFFF;
      z_sat_nxt = 1'b1;
    end
  end
`else
  assign z_nxt     = 16'h0000;
  assign z_sat_nxt = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      ovf_pos <= 1'b0;
      ovf_neg <= 1'b0;
      o_mac   <= '0;
      o_ir    <= '0;
      o_irSat <= 1'b0;
      o_z16   <= '0;
      o_zSat  <= 1'b0;
    end else if (take) begin
      acc     <= acc_nxt;
      ovf_pos <= ovp | (~load & ovf_pos);
      ovf_neg <= ovn | (~load & ovf_neg);
      state   <= i_last ? DONE : ACCUM;
      if (i_last) begin
        o_mac   <= mac[31:0];
        o_ir    <= ir_nxt;
        o_irSat <= ir_sat_nxt;
        o_z16   <= z_nxt;
        o_zSat  <= z_sat_nxt;
      end
    end else if (state == DONE && i_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_gte_dot_accum.sv
// tb_gte_dot_accum: directed stimulus for gte_dot_accum checked against
// an arithmetic reference model plus literal expectations.
module tb_gte_dot_accum;

  localparam longint AMAX = (64'sd1 <<< 43) - 1;
  localparam longint AMIN = -(64'sd1 <<< 43);

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_first = 1'b0;
  logic        i_last = 1'b0;
  logic [47:0] i_a = '0;
  logic [47:0] i_b = '0;
  logic [2:0]  i_neg = '0;
  logic [43:0] i_bias = '0;
  logic        i_sf = 1'b0;
  logic        i_lm = 1'b0;
  logic        i_ready = 1'b1;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_mac;
  logic [15:0] o_ir;
  logic        o_irSat;
  logic        o_ovfPos;
  logic        o_ovfNeg;
  logic [15:0] o_z16;
  logic        o_zSat;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  gte_dot_accum dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_first  (i_first),
    .i_last   (i_last),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_neg    (i_neg),
    .i_bias   (i_bias),
    .i_sf     (i_sf),
    .i_lm     (i_lm),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_mac    (o_mac),
    .o_ir     (o_ir),
    .o_irSat  (o_irSat),
    .o_ovfPos (o_ovfPos),
    .o_ovfNeg (o_ovfNeg),
    .o_z16    (o_z16),
    .o_zSat   (o_zSat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic longint wrap44(input longint v);
    longint m;
    m = v & ((64'sd1 <<< 44) - 1);
    if (m[43]) m = m - (64'sd1 <<< 44);
    return m;
  endfunction

  function automatic logic [47:0] pk(input int l2, input int l1,
                                     input int l0);
    return {l2[15:0], l1[15:0], l0[15:0]};
  endfunction

  // Reference model: plain integer arithmetic on whole operations.
  bit          m_open = 1'b0;
  bit          m_valid = 1'b0;
  longint      m_acc = 0;
  bit          m_pos = 1'b0;
  bit          m_neg = 1'b0;
  logic [31:0] m_mac = '0;
  logic [15:0] m_ir = '0;
  bit          m_irsat = 1'b0;
  logic [15:0] m_z = '0;
  bit          m_zsat = 1'b0;

  longint t_s, t_p, t_nv, t_w, t_mac, t_lo, t_ir, t_z;
  bit     t_fresh;

  always @(posedge clk) begin
    if (i_rst) begin
      m_open <= 0; m_valid <= 0; m_acc <= 0;
      m_pos <= 0; m_neg <= 0; m_mac <= '0;
      m_ir <= '0; m_irsat <= 0; m_z <= '0; m_zsat <= 0;
    end else if (i_valid && (!m_valid || i_ready)) begin
      t_s = 0;
      for (int k = 0; k < 3; k++) begin
        t_p = longint'($signed(i_a[k*16 +: 16])) *
              longint'($signed(i_b[k*16 +: 16]));
        t_s = t_s + (i_neg[k] ? -t_p : t_p);
      end
      t_fresh = i_first || !m_open;
      t_nv = (t_fresh ? (i_first ? longint'($signed(i_bias)) : 0)
                      : m_acc) + t_s;
      t_w = wrap44(t_nv);
      m_pos  <= (t_nv > AMAX) || (!t_fresh && m_pos);
      m_neg  <= (t_nv < AMIN) || (!t_fresh && m_neg);
      m_acc  <= t_w;
      m_open <= !i_last;
      m_valid <= i_last;
      if (i_last) begin
        t_mac = i_sf ? (t_w >>> 12) : t_w;
        t_lo = i_lm ? 0 : -32768;
        t_ir = t_mac > 32767 ? 32767 : (t_mac < t_lo ? t_lo : t_mac);
        m_mac   <= t_mac[31:0];
        m_ir    <= t_ir[15:0];
        m_irsat <= (t_ir != t_mac);
`ifdef GTE_DOT_ACCUM_ZCLAMP_EN
        t_z = t_w >>> 12;
        t_z = t_z < 0 ? 0 : (t_z > 65535 ? 65535 : t_z);
        m_z    <= t_z[15:0];
        m_zsat <= (t_z != (t_w >>> 12));
`endif
      end
    end else if (m_valid && i_ready) begin
      m_valid <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 64'(o_valid), 64'(m_valid));
      chk("ready", 64'(o_ready), 64'(!m_valid || i_ready));
      chk("mac", 64'(o_mac), 64'(m_mac));
      chk("ir", 64'(o_ir), 64'(m_ir));
      chk("irsat", 64'(o_irSat), 64'(m_irsat));
      chk("ovfpos", 64'(o_ovfPos), 64'(m_pos));
      chk("ovfneg", 64'(o_ovfNeg), 64'(m_neg));
      chk("z16", 64'(o_z16), 64'(m_z));
      chk("zsat", 64'(o_zSat), 64'(m_zsat));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [47:0] a, input logic [47:0] b,
                      input logic [2:0] n, input longint bias,
                      input bit first, input bit last,
                      input bit sf, input bit lm);
    i_valid = 1'b1;
    i_a = a; i_b = b; i_neg = n;
    i_bias = bias[43:0];
    i_first = first; i_last = last;
    i_sf = sf; i_lm = lm;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_mac", 64'(o_mac), 64'd0);
    tick();

    // 0x1000*0x1000 >>> 12
    beat(pk(0, 0, 'h1000), pk(0, 0, 'h1000), 3'b000, 0, 1, 1, 1, 0);
    chk("l_mac1", 64'(o_valid), 64'd1);
    chk("l_mac1", 64'(o_mac), 64'h1000);
    chk("l_ir1", 64'(o_ir), 64'h1000);
    chk("l_sat1", 64'(o_irSat), 64'd0);
    tick();

    // negative product, lower limit 0
    beat(pk(0, 0, -256), pk(0, 0, 'h1000), 3'b000, 0, 1, 1, 0, 1);
    chk("l_mac2", 64'(o_mac), 64'hFFF00000);
    chk("l_ir2", 64'(o_ir), 64'd0);
    chk("l_sat2", 64'(o_irSat), 64'd1);
    tick();

    // three beats, bias 5
    beat(pk(0, 0, 1), pk(0, 0, 1), 3'b000, 5, 1, 0, 0, 0);
    chk("l_busy1", 64'(o_valid), 64'd0);
    beat(pk(0, 0, 1), pk(0, 0, 1), 3'b000, 0, 0, 0, 0, 0);
    chk("l_busy2", 64'(o_valid), 64'd0);
    beat(pk(0, 0, 1), pk(0, 0, 1), 3'b000, 0, 0, 1, 0, 0);
    chk("l_mac3", 64'(o_mac), 64'd8);
    tick();

    // positive overflow, then cleared by next op
    beat(pk(0, 0, 1), pk(0, 0, 1), 3'b000, 64'sh7FFFFFFFFFF, 1, 1, 0, 0);
    chk("l_ovp", 64'(o_ovfPos), 64'd1);
    chk("l_ovn", 64'(o_ovfNeg), 64'd0);
    beat(pk(0, 0, 0), pk(0, 0, 0), 3'b000, 0, 1, 1, 0, 0);
    chk("l_ovclr", 64'(o_ovfPos), 64'd0);
    tick();

    // negative overflow
    beat(pk(0, 0, -1), pk(0, 0, 1), 3'b000, AMIN, 1, 1, 0, 0);
    chk("l_ovn2", 64'(o_ovfNeg), 64'd1);
    tick();

    // back-pressure hold, then take with a new beat
    beat(pk(0, 0, 2), pk(0, 0, 3), 3'b000, 0, 1, 1, 0, 0);
    i_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("l_hold_v", 64'(o_valid), 64'd1);
      chk("l_hold_r", 64'(o_ready), 64'd0);
      chk("l_hold_m", 64'(o_mac), 64'd6);
    end
    i_ready = 1'b1;
    beat(pk(0, 0, 4), pk(0, 0, 5), 3'b000, 0, 1, 1, 0, 0);
    chk("l_take", 64'(o_mac), 64'd20);
    tick();

    // all lanes with one negate: -30 + 8 + 21 + 100
    beat(pk(3, -2, 5), pk(7, 4, -6), 3'b010, 100, 1, 1, 0, 0);
    chk("l_lanes", 64'(o_mac), 64'd99);
    tick();

    // largest products, IR positive clamp
    beat(pk(-32768, -32768, -32768), pk(-32768, -32768, -32768),
         3'b000, 0, 1, 1, 1, 0);
    chk("l_big", 64'(o_mac), 64'h000C0000);
    chk("l_bigir", 64'(o_ir), 64'h7FFF);
    tick();

    // abandoned operation, then fresh single beat
    beat(pk(0, 0, 9), pk(0, 0, 9), 3'b000, 0, 1, 0, 0, 0);
    beat(pk(0, 0, 2), pk(0, 0, 2), 3'b000, 7, 1, 1, 0, 0);
    chk("l_abandon", 64'(o_mac), 64'd11);
    tick();

    // beat in IDLE without first ignores bias
    beat(pk(0, 0, 3), pk(0, 0, 3), 3'b000, 1000, 0, 1, 0, 0);
    chk("l_nofirst", 64'(o_mac), 64'd9);
    tick();

`ifdef GTE_DOT_ACCUM_ZCLAMP_EN
    beat(pk(0, 0, 0), pk(0, 0, 0), 3'b000, 64'h10000000, 1, 1, 0, 0);
    chk("l_z16", 64'(o_z16), 64'hFFFF);
    chk("l_zsat", 64'(o_zSat), 64'd1);
    tick();
`else
    beat(pk(0, 0, 0), pk(0, 0, 0), 3'b000, 64'h10000000, 1, 1, 0, 0);
    chk("l_z16off", 64'(o_z16), 64'd0);
    tick();
`endif

    // reset mid-operation
    beat(pk(0, 0, 5), pk(0, 0, 5), 3'b000, 0, 1, 0, 0, 0);
    i_rst = 1'b1;
    tick();
    chk("l_rstv", 64'(o_valid), 64'd0);
    chk("l_rstr", 64'(o_ready), 64'd1);
    i_rst = 1'b0;
    beat(pk(0, 0, 1), pk(0, 0, 1), 3'b000, 0, 0, 1, 0, 0);
    chk("l_after", 64'(o_mac), 64'd1);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
